// File: rtl/div_pkg.sv
// div_pkg -- shared types and helpers for the iterative divider.
//   div_op_e : operation encoding carried on i_div_op
//   state_e  : divider control states
//   helpers  : operation class decode and two's-complement magnitude
package div_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

  // 0x80000000 maps to itself, which read unsigned is the correct 2^31.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// adder_32bit -- plain 32-bit adder with carry in/out.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : a_i + b_i + cin_i (low 32 bits)
//   cout_o   : carry out
import div_pkg::*;

module adder_32bit (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cin_i,
  output logic [XLEN-1:0] sum_o,
  output logic            cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{XLEN{1'b0}}, cin_i};

endmodule

// File: rtl/div_unit.sv
// div_unit -- 32-cycle restoring divider for DIV/DIVU/REM/REMU.
//   i_clk, i_reset        : clock, async active-high reset
//   i_valid, o_ready      : request handshake (accepted when both high)
//   i_div_op, i_op_a/b    : operation, dividend, divisor
//   o_valid, o_div_data   : one-cycle result strobe and registered result
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one quotient bit per cycle, 32 cycles
// DONE  | result presented with o_valid for one cycle
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [1:0]       i_div_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_div_data
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  div_op_e            op_q, op_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [WIDTH-1:0]   rem_shift, diff, rem_next, quo_next;
  logic [WIDTH-1:0]   q_fin, r_fin;
  logic               carry, no_borrow;
  div_op_e            op_in;
  logic               sgn_in, ovf_in;

  // Trial subtraction rem_shift - divisor as rem_shift + ~divisor + 1.
  assign rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  adder_32bit u_sub (
    .a_i   (rem_shift),
    .b_i   (~dvsr_q),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(carry)
  );

  // A bit shifted out of rem means the partial remainder is >= 2^32 and
  // therefore exceeds any divisor; the wrapped 32-bit difference is exact.
  assign no_borrow = carry | rem_q[WIDTH-1];
  assign rem_next  = no_borrow ? diff : rem_shift;
  assign quo_next  = {quo_q[WIDTH-2:0], no_borrow};
  assign r_fin     = neg_rem_q ? -rem_next : rem_next;
  assign q_fin     = neg_quo_q ? -quo_next : quo_next;

  assign op_in  = div_op_e'(i_div_op);
  assign sgn_in = op_is_signed(op_in);
  assign ovf_in = sgn_in && (i_op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op_b == '1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d      = op_in;
          rem_d     = '0;
          quo_d     = sgn_in ? magnitude(i_op_a) : i_op_a;
          dvsr_d    = sgn_in ? magnitude(i_op_b) : i_op_b;
          neg_quo_d = sgn_in && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
          neg_rem_d = sgn_in && i_op_a[WIDTH-1];
          cnt_d     = '0;
          if (i_op_b == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
            data_d  = op_is_rem(op_in) ? i_op_a : '1;
          end else if (ovf_in) begin
            state_d = DONE;
            valid_d = 1'b1;
            data_d  = op_is_rem(op_in) ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = DONE;
          valid_d = 1'b1;
          data_d  = op_is_rem(op_q) ? r_fin : q_fin;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= DIVU;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = valid_q;
  assign o_div_data = data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- scoreboard bench for div_unit: directed corner cases, a
// mid-calculation reset, busy-time request holding and random operations
// checked against an arithmetic reference model.
import div_pkg::*;

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [1:0]  i_div_op;
  logic [31:0] i_op_a, i_op_b;
  logic        o_ready, o_valid;
  logic [31:0] o_div_data;

  div_unit #(.WIDTH(32)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_valid   (i_valid),
    .i_div_op  (i_div_op),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_div_data(o_div_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
    logic [1:0]  op;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; 64-bit signed division gives the
  // overflow case (2^31 truncated to 32 bits, remainder 0) for free.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return 32'(sa / sb_);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb_);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a falling edge. Holds i_valid until accepted; with churn set the
  // operands change every cycle the DUT is busy, so only the accepted set counts.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit churn, output int waited);
    exp_t e;
    waited = 0;
    forever begin
      i_valid = 1'b1; i_div_op = op; i_op_a = a; i_op_b = b;
      #1;
      if (o_ready) begin
        e.data = ref_div(op, a, b);
        e.acc  = cyc + 1;
        e.lat  = ref_lat(op, a, b);
        e.op   = op;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: o_ready=%0b expected 1 within 200 cycles", o_ready);
        break;
      end
      @(negedge clk);
      if (churn) begin
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Monitor: every o_valid cycle must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_valid: o_valid=1 data=0x%08h expected no result", o_div_data);
      end else begin
        e = sb.pop_front();
        check($sformatf("data op=%0d", e.op), o_div_data, e.data);
        check($sformatf("latency op=%0d", e.op), 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  initial begin
    int w;
    logic [1:0]  op;
    logic [31:0] a, b;

    rst = 1'b1; i_valid = 1'b0; i_div_op = 2'b00; i_op_a = '0; i_op_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_data", o_div_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(DIVU, 32'd100, 32'd7, 1'b0, w);
    check("post_reset_accept_wait", 32'(w), 32'd0);
    issue(REMU, 32'd100, 32'd7, 1'b0, w);
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, w);
    issue(REM,  32'hFFFF_FFF9, 32'd2, 1'b0, w);
    issue(DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, w);
    issue(DIVU, 32'h1234, 32'd0, 1'b0, w);
    issue(REMU, 32'h1234, 32'd0, 1'b0, w);
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, w);
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, w);
    issue(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, w);
    issue(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, w);

    // Busy-time churn: the first request is held while the DUT finishes the
    // previous one, changing every cycle; then a second one waits behind it.
    issue(DIVU, 32'd1000, 32'd3, 1'b1, w);
    issue(REM, 32'h8765_4321, 32'h0000_0123, 1'b1, w);
    check("busy_wait_nonzero", 32'(w > 0), 32'd1);

    // Reset in the 10th CALC cycle of a long op: its result must never appear.
    issue(DIVU, 32'hDEAD_BEEF, 32'd17, 1'b0, w);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_data", o_div_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(DIVU, 32'd50, 32'd5, 1'b0, w);
    check("abort_next_accept_wait", 32'(w), 32'd0);

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(op, a, b, bit'(i % 3 == 0), w);
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
      check("pending_results", 32'(sb.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
